// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RMW_WRITE = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // Byte lanes with be set take wdata, the rest keep the word read from memory.
  function automatic logic [31:0] lane_merge(input logic [3:0]  be,
                                             input logic [31:0] wdata,
                                             input logic [31:0] rdata);
    logic [31:0] m;
    m = rdata;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = wdata[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two-port request/response bundle between requesters and dmem_arbiter.
interface dmem_arbiter_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_be;
  logic [1:0]       resp_valid;
  logic [31:0]      resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-requester round-robin grant; last_grant moves only when a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= 1'b1;
    else      last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port front end for the single-port data memory: loads, word stores and
// read-modify-write sub-word stores, one response per accepted request.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 7
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic [31:0]    mem_read_addr,
  input  logic [31:0]    mem_read_data,
  output logic [31:0]    mem_write_addr,
  output logic [31:0]    mem_write_data,
  output logic           mem_write_enable
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        port_q, port_d;
  logic [1:0]  resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [1:0]  gnt;
  logic        accept;
  logic        sel;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_be;
  logic        cur_we;
  logic        err;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  // Ready is masked while reset is held so nothing can be accepted (or written) then.
  assign bus.req_ready = (state_q == IDLE && rst) ? gnt : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign sel           = gnt[1];
  assign cur_addr      = bus.req_addr[sel];
  assign cur_wdata     = bus.req_wdata[sel];
  assign cur_be        = bus.req_be[sel];
  assign cur_we        = bus.req_we[sel];
  assign err           = |cur_addr[31:ADDR_SIZE+1];

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    be_d             = be_q;
    port_d           = port_q;
    resp_valid_d     = '0;
    resp_rdata_d     = '0;
    resp_err_d       = 1'b0;
    mem_read_addr    = addr_q;
    mem_write_addr   = addr_q;
    mem_write_data   = cur_wdata;
    mem_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        mem_read_addr  = cur_addr;
        mem_write_addr = cur_addr;
        if (accept) begin
          addr_d  = cur_addr;
          wdata_d = cur_wdata;
          be_d    = cur_be;
          port_d  = sel;
          if (err) begin
            resp_valid_d[sel] = 1'b1;
            resp_err_d        = 1'b1;
          end else if (!cur_we) begin
            state_d = RD_WAIT;
          end else if (cur_be == BE_WORD) begin
            mem_write_enable  = 1'b1;
            resp_valid_d[sel] = 1'b1;
          end else if (cur_be == BE_NONE) begin
            resp_valid_d[sel] = 1'b1;
          end else begin
            state_d = RMW_WRITE;
          end
        end
      end
      RD_WAIT: begin
        resp_valid_d[port_q] = 1'b1;
        resp_rdata_d         = mem_read_data;
        state_d              = IDLE;
      end
      RMW_WRITE: begin
        mem_write_enable     = 1'b1;
        mem_write_data       = lane_merge(be_q, wdata_q, mem_read_data);
        resp_valid_d[port_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      port_q       <= 1'b0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      port_q       <= port_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter against a behavioural single-port memory.
module tb_dmem_arbiter;

  localparam int AS = 7;

  logic        clk;
  logic        rst;
  logic [31:0] mem_read_addr, mem_read_data;
  logic [31:0] mem_write_addr, mem_write_data;
  logic        mem_write_enable;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.ADDR_SIZE(AS)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .mem_read_addr    (mem_read_addr),
    .mem_read_data    (mem_read_data),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable)
  );

  // Data memory: registered read returns old data on a same-word write.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    mem_read_data <= mem[mem_read_addr[AS:2]];
    if (mem_write_enable) mem[mem_write_addr[AS:2]] <= mem_write_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we_c0;
    logic        we_c1;
    logic [31:0] wd;
    int          rcyc;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  function automatic vec_t mk(int port, logic we, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, logic we_c0, logic we_c1, logic [31:0] wd,
                              int rcyc, logic [31:0] rdata, logic err);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.we_c0 = we_c0; v.we_c1 = we_c1; v.wd = wd; v.rcyc = rcyc;
    v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] oh;
    oh = (v.port == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    bus.req_valid          = oh;
    bus.req_we[v.port]     = v.we;
    bus.req_addr[v.port]   = v.addr;
    bus.req_wdata[v.port]  = v.wdata;
    bus.req_be[v.port]     = v.be;
    #1;
    chk($sformatf("v%0d c0 ready", idx), {30'b0, bus.req_ready}, {30'b0, oh});
    chk($sformatf("v%0d c0 we", idx), {31'b0, mem_write_enable}, {31'b0, v.we_c0});
    if (v.we_c0) begin
      chk($sformatf("v%0d c0 wdata", idx), mem_write_data, v.wd);
      chk($sformatf("v%0d c0 waddr", idx), {26'b0, mem_write_addr[AS:2]}, {26'b0, v.addr[AS:2]});
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk($sformatf("v%0d c1 we", idx), {31'b0, mem_write_enable}, {31'b0, v.we_c1});
    if (v.we_c1) begin
      chk($sformatf("v%0d c1 wdata", idx), mem_write_data, v.wd);
      chk($sformatf("v%0d c1 waddr", idx), {26'b0, mem_write_addr[AS:2]}, {26'b0, v.addr[AS:2]});
    end
    chk($sformatf("v%0d c1 resp_valid", idx), {30'b0, bus.resp_valid},
        (v.rcyc == 1) ? {30'b0, oh} : 32'h0);
    if (v.rcyc == 1) begin
      chk($sformatf("v%0d c1 rdata", idx), bus.resp_rdata, v.rdata);
      chk($sformatf("v%0d c1 err", idx), {31'b0, bus.resp_err}, {31'b0, v.err});
    end
    @(negedge clk);
    #1;
    chk($sformatf("v%0d c2 we", idx), {31'b0, mem_write_enable}, 32'h0);
    chk($sformatf("v%0d c2 resp_valid", idx), {30'b0, bus.resp_valid},
        (v.rcyc == 2) ? {30'b0, oh} : 32'h0);
    if (v.rcyc == 2) begin
      chk($sformatf("v%0d c2 rdata", idx), bus.resp_rdata, v.rdata);
      chk($sformatf("v%0d c2 err", idx), {31'b0, bus.resp_err}, {31'b0, v.err});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[$];
    logic [1:0] g[4];
    int         gc[4];
    int         ng;

    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset resp_valid", {30'b0, bus.resp_valid}, 32'h0);
    chk("reset resp_rdata", bus.resp_rdata, 32'h0);
    chk("reset resp_err", {31'b0, bus.resp_err}, 32'h0);
    chk("reset we", {31'b0, mem_write_enable}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Fairness: both ports hold loads; grants alternate starting with port 0, every 2 cycles
    @(negedge clk);
    bus.req_valid   = 2'b11;
    bus.req_we      = 2'b00;
    bus.req_addr[0] = 32'h10;
    bus.req_addr[1] = 32'h20;
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        g[ng]  = bus.req_ready;
        gc[ng] = c;
        ng++;
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    chk("fair grant count", ng, 4);
    for (int k = 0; k < ng; k++) begin
      chk($sformatf("fair grant %0d", k), {30'b0, g[k]}, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("fair cycle %0d", k), gc[k], 2 * k);
    end
    repeat (2) @(negedge clk);

    // Back-to-back word stores from port 0
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid    = 2'b01;
      bus.req_we[0]    = 1'b1;
      bus.req_addr[0]  = 32'(4 * i);
      bus.req_wdata[0] = 32'hB0B0_0000 + 32'(i);
      bus.req_be[0]    = 4'hF;
      #1;
      chk($sformatf("b2b%0d ready", i), {30'b0, bus.req_ready}, 32'h1);
      chk($sformatf("b2b%0d we", i), {31'b0, mem_write_enable}, 32'h1);
      chk($sformatf("b2b%0d resp", i), {30'b0, bus.resp_valid}, (i > 0) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("b2b tail resp", {30'b0, bus.resp_valid}, 32'h1);
    chk("b2b tail we", {31'b0, mem_write_enable}, 32'h0);
    @(negedge clk);
    #1;
    chk("b2b idle resp", {30'b0, bus.resp_valid}, 32'h0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b mem%0d", i), mem[i], 32'hB0B0_0000 + 32'(i));

    // Single-transaction vectors
    tbl.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, 32'hDEADBEEF, 1, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h10, 32'h0,        4'h0, 0, 0, 32'h0,        2, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 1, 32'h20, 32'h11223344, 4'hF, 1, 0, 32'h11223344, 1, 32'h0, 0));
    tbl.push_back(mk(1, 1, 32'h20, 32'h0000AA00, 4'h2, 0, 1, 32'h1122AA44, 2, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h20, 32'h0,        4'h0, 0, 0, 32'h0,        2, 32'h1122AA44, 0));
    tbl.push_back(mk(0, 1, 32'h00, 32'h55667788, 4'hF, 1, 0, 32'h55667788, 1, 32'h0, 0));
    tbl.push_back(mk(1, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0,       1, 32'h0, 1));
    tbl.push_back(mk(0, 0, 32'h00, 32'h0,        4'h0, 0, 0, 32'h0,        2, 32'h55667788, 0));
    tbl.push_back(mk(1, 0, 32'h200, 32'h0,       4'h0, 0, 0, 32'h0,        1, 32'h0, 1));
    tbl.push_back(mk(0, 1, 32'h00, 32'h0,        4'h0, 0, 0, 32'h0,        1, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h00, 32'h0,        4'h0, 0, 0, 32'h0,        2, 32'h55667788, 0));
    tbl.push_back(mk(1, 1, 32'h00, 32'hAABBCCDD, 4'h9, 0, 1, 32'hAA6677DD, 2, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h00, 32'h0,        4'h0, 0, 0, 32'h0,        2, 32'hAA6677DD, 0));
    tbl.push_back(mk(0, 0, 32'h23, 32'h0,        4'h0, 0, 0, 32'h0,        2, 32'h1122AA44, 0));
    tbl.push_back(mk(1, 1, 32'h13, 32'h00550000, 4'h4, 0, 1, 32'hDE55BEEF, 2, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h10, 32'h0,        4'h0, 0, 0, 32'h0,        2, 32'hDE55BEEF, 0));
    tbl.push_back(mk(0, 1, 32'h30, 32'h12345678, 4'hF, 1, 0, 32'h12345678, 1, 32'h0, 0));
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Reset asserted during RMW_WRITE
    @(negedge clk);
    bus.req_valid    = 2'b10;
    bus.req_we[1]    = 1'b1;
    bus.req_addr[1]  = 32'h30;
    bus.req_wdata[1] = 32'h000000EE;
    bus.req_be[1]    = 4'h1;
    #1;
    chk("rmwrst ready", {30'b0, bus.req_ready}, 32'h2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("rmwrst we before", {31'b0, mem_write_enable}, 32'h1);
    chk("rmwrst wdata before", mem_write_data, 32'h123456EE);
    rst = 1'b0;
    #1;
    chk("rmwrst we dropped", {31'b0, mem_write_enable}, 32'h0);
    chk("rmwrst resp_valid", {30'b0, bus.resp_valid}, 32'h0);
    chk("rmwrst rdata", bus.resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rmwrst word kept", mem[12], 32'h12345678);
    chk("rmwrst resp held", {30'b0, bus.resp_valid}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    bus.req_valid   = 2'b11;
    bus.req_we      = 2'b00;
    bus.req_addr[0] = 32'h30;
    bus.req_addr[1] = 32'h30;
    #1;
    chk("post-reset grant", {30'b0, bus.req_ready}, 32'h1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    @(negedge clk);
    #1;
    chk("post-reset load", bus.resp_rdata, 32'h12345678);
    chk("post-reset resp", {30'b0, bus.resp_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port front end for the single-port data memory, which has 1-cycle registered read, a word-only write, and word index = addr[ADDR_SIZE:2].
- Port 0 is the CPU load/store unit; port 1 is the debug/loader path.
- Arbitrates round-robin between the ports, sequences loads, word stores and byte-enable stores (sub-word stores run as read-modify-write), and returns one response per accepted request.

Parameters:
- ADDR_SIZE, 7, top byte-address bit used by the data memory. Must equal the memory's ADDR_SIZE; word count is 2**(ADDR_SIZE-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  2  per-port request valid. Must be held stable with all req_* fields until accepted.
- req_ready  out  2  per-port accept. Request accepted when valid && ready.
- req_we  in  2  per-port: 1 = store, 0 = load.
- req_addr  in  2x32  per-port byte address.
- req_wdata  in  2x32  per-port store data, lanes aligned to the word.
- req_be  in  2x4  per-port byte enables, lane i = bits [8i+7:8i].
- resp_valid  out  2  per-port 1-cycle response pulse. No backpressure.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  out-of-range address, qualified by resp_valid.
- mem_read_addr  out  32  to memory read_addr.
- mem_read_data  in  32  from memory read_data.
- mem_write_addr  out  32  to memory write_addr.
- mem_write_data  out  32  to memory write_data.
- mem_write_enable  out  1  to memory write_enable.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE; last_grant = 1, so port 0 wins the first tie.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_write_enable = 0 immediately; it is decoded from state, so an in-flight RMW write is dropped.
- State machine: states IDLE, RD_WAIT, RMW_WRITE.
- req_ready is nonzero only in IDLE: one-hot to the granted valid port.
  - Only one port valid: that port is granted.
  - Both valid: grant the port != last_grant.
  - last_grant updates on accept.
- mem addresses:
  - In IDLE, mem_read_addr and mem_write_addr = req_addr of the granted port.
  - Otherwise they come from the latched addr_q.
  - Only bits [ADDR_SIZE:2] matter; addr[1:0] are ignored.
- Range check: err = |addr[31:ADDR_SIZE+1]. On err:
  - no write occurs;
  - response is issued in cycle 1 with resp_err=1, resp_rdata=0;
  - state stays IDLE.
- Let cycle 0 be the accept cycle. Per request type:
  - Load: read issued in cycle 0; RD_WAIT in cycle 1 latches mem_read_data; resp_valid and data in cycle 2; state is IDLE in cycle 2.
  - Word store (be=4'hF): mem_write_enable=1 with req_wdata in cycle 0, state stays IDLE; resp_valid in cycle 1.
  - Partial store (be not 0 and not F): cycle 0 issues the read and latches wdata/be/port; cycle 1 (RMW_WRITE) writes lane-wise merge(be ? wdata : mem_read_data) with mem_write_enable=1; resp_valid in cycle 2.
  - be=4'h0 store: no write; resp_valid in cycle 1.
- New accept is allowed in any IDLE cycle, including the cycle in which a response is pulsing.
  - Peak rate: 1 word store per cycle, 1 load per 2 cycles.
- Memory hazard: memory reads the old data when the same word is written in the same cycle. The arbiter never overlaps an RMW read with a pending write, so this hazard cannot occur.
- Response port = the latched port of the completing request. Only one bit of resp_valid is ever high.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE, RD_WAIT, RMW_WRITE);
  - BE_WORD = 4'hF, BE_NONE = 4'h0;
  - lane-merge function.
- Sub-module rr_arbiter2: 2-request round-robin grant with last_grant register and update-on-accept input. Reused elsewhere for shared resources.

Test Plan:
- Word store then load: port 0 stores 0xDEADBEEF to 0x10, then loads 0x10 → mem_write_enable only in cycle 0; load resp_valid[0] 2 cycles after accept, resp_rdata = 0xDEADBEEF.
- Byte store RMW: word 0x20 = 0x11223344; port 1 store be=4'b0010, wdata=0x0000AA00 → write in cycle 1 of 0x1122AA44; resp_valid[1] in cycle 2; a later load returns 0x1122AA44.
- Fairness: both ports hold valid loads continuously → grants alternate 0,1,0,1 starting with port 0 after reset; no port waits more than one transaction.
- Out-of-range: store to 0x0000_0100 with ADDR_SIZE=7 → no write_enable, resp_err=1 in cycle 1, and the word at 0x00 is unchanged.
- Reset mid-RMW: assert rst low during RMW_WRITE → mem_write_enable drops immediately, target word unchanged, all resp_valid=0; after release, port 0 is granted first.
- Back-to-back word stores from port 0 only: 4 stores to 0x0,0x4,0x8,0xC → accepted in 4 consecutive cycles, 4 resp_valid pulses, each 1 cycle after its accept.
